// File: rtl/tdp_ram_clr_if.sv
// tdp_ram_clr_if: port bundle for both RAM ports plus the clear/busy handshake
interface tdp_ram_clr_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  logic                  clr;
  logic                  busy;
  logic                  en_a;
  logic [NB-1:0]         we_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] din_a;
  logic [DATA_WIDTH-1:0] dout_a;
  logic                  valid_a;
  logic                  en_b;
  logic [NB-1:0]         we_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] din_b;
  logic [DATA_WIDTH-1:0] dout_b;
  logic                  valid_b;
  modport master (
    output clr, en_a, we_a, addr_a, din_a, en_b, we_b, addr_b, din_b,
    input  busy, dout_a, valid_a, dout_b, valid_b
  );
  modport slave (
    input  clr, en_a, we_a, addr_a, din_a, en_b, we_b, addr_b, din_b,
    output busy, dout_a, valid_a, dout_b, valid_b
  );
endinterface

// File: rtl/tdp_ram_clr.sv
// tdp_ram_clr: true dual-port byte-writable RAM with zero-fill sequencer; TDP_RAM_CLR_OUTREG_EN adds an output register stage
module tdp_ram_clr #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int RDW_MODE   = 0
) (
  input logic          clk,
  input logic          rst,
  tdp_ram_clr_if.slave bus
);
  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;
  logic [DATA_WIDTH-1:0] r_ram [DEPTH];
  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [DATA_WIDTH-1:0] r_dout_a, r_dout_b;
  logic                  r_valid_a, r_valid_b;
  logic                  w_busy, w_acc_a, w_acc_b;
  function automatic logic [DATA_WIDTH-1:0] f_merge(
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] din,
    input logic [NB-1:0]         we
  );
    logic [DATA_WIDTH-1:0] w;
    w = old;
    for (int i = 0; i < NB; i++)
      if (we[i]) w[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
    return w;
  endfunction
  assign w_busy   = r_state == S_CLEAR;
  assign w_acc_a  = !rst && !w_busy && bus.en_a;
  assign w_acc_b  = !rst && !w_busy && bus.en_b;
  assign bus.busy = w_busy;
  // clear sequencer: reset or an idle clr pulse restarts the zero-fill from address 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
      if (&r_clr_cnt) r_state <= S_IDLE;
    end else if (bus.clr) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end
  end
  // array writes; A lanes are applied last so A wins lanes both ports write at one address
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_ram[r_clr_cnt] <= '0;
    end else begin
      for (int i = 0; i < NB; i++)
        if (w_acc_b && bus.we_b[i]) r_ram[bus.addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      for (int i = 0; i < NB; i++)
        if (w_acc_a && bus.we_a[i]) r_ram[bus.addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end
  // read stage: old word (read-first) or own-port merged word (write-first); holds when not accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout_a  <= '0;
      r_dout_b  <= '0;
      r_valid_a <= 1'b0;
      r_valid_b <= 1'b0;
    end else begin
      r_valid_a <= w_acc_a;
      r_valid_b <= w_acc_b;
      if (w_acc_a) r_dout_a <= RDW_MODE != 0 ? r_ram[bus.addr_a] : f_merge(r_ram[bus.addr_a], bus.din_a, bus.we_a);
      if (w_acc_b) r_dout_b <= RDW_MODE != 0 ? r_ram[bus.addr_b] : f_merge(r_ram[bus.addr_b], bus.din_b, bus.we_b);
    end
  end
`ifdef TDP_RAM_CLR_OUTREG_EN
  logic [DATA_WIDTH-1:0] r_dout2_a, r_dout2_b;
  logic                  r_valid2_a, r_valid2_b;
  // second output stage: captures only fresh read data so it holds between accesses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout2_a  <= '0;
      r_dout2_b  <= '0;
      r_valid2_a <= 1'b0;
      r_valid2_b <= 1'b0;
    end else begin
      r_valid2_a <= r_valid_a;
      r_valid2_b <= r_valid_b;
      if (r_valid_a) r_dout2_a <= r_dout_a;
      if (r_valid_b) r_dout2_b <= r_dout_b;
    end
  end
  assign bus.dout_a  = r_dout2_a;
  assign bus.dout_b  = r_dout2_b;
  assign bus.valid_a = r_valid2_a;
  assign bus.valid_b = r_valid2_b;
`else
  assign bus.dout_a  = r_dout_a;
  assign bus.dout_b  = r_dout_b;
  assign bus.valid_a = r_valid_a;
  assign bus.valid_b = r_valid_b;
`endif
endmodule
